// File: rtl/seg_scan_if.sv
// seg_scan_if: digit-pattern bus between the pattern producers and the
// seven-segment scan driver.
//   dig0..dig3  : active-low {dp,g..a} patterns, digit 0 rightmost
//   seg         : active-low segment lines
//   an          : active-low anode selects
//   frame_start : one-cycle pulse in the first cycle of slot 0
interface seg_scan_if;
   logic [7:0] dig0;
   logic [7:0] dig1;
   logic [7:0] dig2;
   logic [7:0] dig3;
   logic [7:0] seg;
   logic [3:0] an;
   logic       frame_start;

   // Producer side: drives patterns, observes display lines
   modport master (
      output dig0, dig1, dig2, dig3,
      input  seg, an, frame_start
   );

   // Scan driver side
   modport slave (
      input  dig0, dig1, dig2, dig3,
      output seg, an, frame_start
   );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for a 4-digit common-anode display.
// Snapshots four segment patterns once per frame and scans one digit per
// slot, with an all-anodes-off gap at the start of each slot.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : seg_scan_if.slave (dig0..dig3 in; seg, an, frame_start out, all registered)
module seg_scan #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   seg_scan_if.slave  bus
);

   localparam int unsigned CNT_W     = $clog2(REFRESH_DIV);
   localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } phase_t;

   // Registered state: describes the cycle currently on the outputs
   phase_t           phase;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             running;
   logic [7:0]       snap [4];
   logic [7:0]       seg_q;
   logic [3:0]       an_q;
   logic             fs_q;

   // Next-state values
   phase_t           phase_n;
   logic [CNT_W-1:0] cnt_n;
   logic [1:0]       idx_n;
   logic             load;
   logic             wrap;
   logic [7:0]       seg_n;
   logic [3:0]       an_n;
   logic             fs_n;

   // Phase register
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= BLANK;
      end else begin
         phase <= phase_n;
      end
   end

   // Slot counter, digit index and frame snapshot; first edge out of reset
   // restarts at slot 0 and reloads the snapshot
   always_comb begin
      cnt_n   = cnt;
      idx_n   = idx;
      load    = 1'b0;
      wrap    = 1'b0;
      phase_n = phase;
      if (!running) begin
         cnt_n = '0;
         idx_n = '0;
         load  = 1'b1;
         wrap  = 1'b1;
      end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_n = '0;
         idx_n = idx + 2'd1;
         load  = (idx == 2'd3);
         wrap  = 1'b1;
      end else begin
         cnt_n = cnt + CNT_W'(1);
      end

      // Each slot opens in BLANK (if any) and moves to SHOW once the gap ends
      if (wrap) begin
         phase_n = HAS_BLANK ? BLANK : SHOW;
      end else if (phase == BLANK && 32'(cnt_n) == BLANK_CYCLES) begin
         phase_n = SHOW;
      end
   end

   // Output decode for the upcoming cycle; on a load edge digit 0 comes
   // straight from the inputs being captured
   always_comb begin
      seg_n = 8'hFF;
      an_n  = 4'hF;
      fs_n  = load;
      if (phase_n == SHOW) begin
         an_n  = ~(4'b0001 << idx_n);
         seg_n = load ? bus.dig0 : snap[idx_n];
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= '0;
         running <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            snap[i] <= 8'hFF;
         end
         seg_q   <= 8'hFF;
         an_q    <= 4'hF;
         fs_q    <= 1'b0;
      end else begin
         cnt     <= cnt_n;
         idx     <= idx_n;
         running <= 1'b1;
         if (load) begin
            snap[0] <= bus.dig0;
            snap[1] <= bus.dig1;
            snap[2] <= bus.dig2;
            snap[3] <= bus.dig3;
         end
         seg_q   <= seg_n;
         an_q    <= an_n;
         fs_q    <= fs_n;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.an          = an_q;
   assign bus.frame_start = fs_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the blink stage and the other digit-pattern producers. It takes four 8-bit active-low segment patterns, one per digit, snapshots them once per frame, and drives one digit at a time. A blanking gap at the start of every digit slot suppresses ghosting.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz frame). Must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV; 0 means no blanking.

Ports:
- clk, input, 1: system clock. One clock domain; all logic on posedge clk.
- rst, input, 1: reset, synchronous, active-high.
- dig0, input, 8: segment pattern for digit 0 (rightmost). Active-low {dp,g..a}; 8'hFF means dark.
- dig1, input, 8: segment pattern for digit 1.
- dig2, input, 8: segment pattern for digit 2.
- dig3, input, 8: segment pattern for digit 3 (leftmost).
- seg, output, 8: active-low segment lines, registered.
- an, output, 4: active-low anode selects, registered. At most one bit low.
- frame_start, output, 1: one-cycle pulse, registered, high in the first cycle of slot 0.

## Operation
- State: slot counter cnt (width $clog2(REFRESH_DIV), range 0..REFRESH_DIV-1), digit index idx (2 bits), phase FSM {BLANK, SHOW}, 4×8 snapshot register.
- cnt increments every cycle. At REFRESH_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
- Phase is BLANK while cnt < BLANK_CYCLES, otherwise SHOW.
  - BLANK: an=4'b1111, seg=8'hFF.
  - SHOW: an=~(4'b0001<<idx), seg=snapshot[idx].
- Snapshot loads dig0..dig3 together at the start of every slot 0:
  - on the first cycle after reset release;
  - on every idx wrap from 3 to 0.
- Inputs changing during a frame have no effect until the next frame. This gives frame-coherent display with no tearing between digits.
- A pattern of 8'hFF (as produced by the blink stage) is displayed as-is. The anode is still driven; the digit is simply dark.
- Reset, from any state or mid-slot:
  - cnt=0, idx=0, phase BLANK;
  - snapshot all 8'hFF;
  - an=4'b1111, seg=8'hFF, frame_start=0.

## Timing
- "Cycle n" means the output values after the n-th rising edge with rst low. Cycle 0 is the first.
- Slot k (k=0..3) in frame f covers cycles t = (4f+k)·REFRESH_DIV + c, for c = 0..REFRESH_DIV-1.
- Cycles with c < BLANK_CYCLES are blank. The remaining cycles show digit k.
- frame_start is 1 exactly at cycles t = 4f·REFRESH_DIV and 0 at all other cycles.
- Snapshot sampling point: dig inputs present before the edge producing cycle 4f·REFRESH_DIV are displayed throughout frame f.
- Output latency: registered. an, seg and frame_start change only on clk edges, never combinationally from dig inputs.
- rst has priority over all counting. Asserting rst on any edge yields reset outputs after that edge. The first edge with rst low restarts at cycle 0 (slot 0, BLANK, snapshot reloaded).
- Anode never changes directly from one digit to another when BLANK_CYCLES ≥ 1. With BLANK_CYCLES=0, slots abut and an changes digit-to-digit in one edge.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2 unless stated.
- **Reset:** hold rst=1 for 3 cycles with arbitrary dig → an=4'b1111, seg=8'hFF, frame_start=0 throughout.
- **Scan order:** dig0=8'hC0, dig1=8'hF9, dig2=8'hA4, dig3=8'hB0, then release rst →
  - cycles 0-1 blank; cycles 2-7 an=1110, seg=C0;
  - cycles 8-9 blank; cycles 10-15 an=1101, seg=F9;
  - cycles 18-23 an=1011, seg=A4; cycles 26-31 an=0111, seg=B0;
  - frame_start=1 only at cycles 0 and 32.
- **Frame coherence:** set dig1=8'h92 at cycle 3 → cycles 10-15 still show F9; cycles 42-47 show an=1101, seg=92.
- **Mid-slot reset:** assert rst for one edge during cycle 13 → next cycle an=1111, seg=FF; after release, sequence restarts exactly as in the scan-order case from cycle 0.
- **Blinked digit:** dig2=8'hFF → cycles 18-23 an=1011, seg=FF; other digits are unaffected.
- **No blanking:** BLANK_CYCLES=0 → cycle 0 an=1110; cycle 8 an=1101; no cycle with an=1111 after reset.
